// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit between the MEM stage and a byte-enable-less bus,
// with sub-word read-modify-write stores, misalignment detection and a bus timeout.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wd,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rd
);
  localparam int BW = DATA_W / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;
  state_t state;
  logic [OW-1:0] off_q;
  logic [1:0] size_q;
  logic uns_q;
  logic [DATA_W-1:0] wd_q;
  logic [CW-1:0] cnt;
  logic [6:0] nb;
  logic [OW+2:0] sa;
  logic [DATA_W-1:0] mask, sh, ld, merged;
  logic full, sgn, mis, fw, ack, tmo;
  always_comb begin
    nb = 7'd8 << size_q;
    full = nb >= 7'(DATA_W);
    mask = full ? '1 : (DATA_W'(1) << nb) - DATA_W'(1);
    sa = {off_q, 3'b000};
    sh = bus_rd >> sa;
    sgn = 1'(sh >> (nb - 7'd1));
    ld = (sh & mask) | ((!uns_q && !full && sgn) ? ~mask : '0);
    merged = (bus_rd & ~(mask << sa)) | ((wd_q & mask) << sa);
    // doubleword accesses have no lane to live in on a 32-bit bus, so they are rejected as misaligned
    mis = (|(req_addr[2:0] & ((3'd1 << req_size) - 3'd1))) || (req_size == 2'd3 && DATA_W == 32);
    fw = (7'd8 << req_size) == 7'(DATA_W);
    ack = bus_req && bus_ack;
    tmo = TIMEOUT > 0 && bus_req && !bus_ack && cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 2'b00;
      busy <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wd <= '0;
      off_q <= '0;
      size_q <= 2'b00;
      uns_q <= 1'b0;
      wd_q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          off_q <= req_addr[OW-1:0];
          size_q <= req_size;
          uns_q <= req_unsigned;
          wd_q <= req_wdata;
          cnt <= '0;
          req_ready <= 1'b0;
          busy <= 1'b1;
          bus_addr <= {req_addr[ADDR_W-1:OW], OW'(0)};
          bus_wd <= req_wdata;
          if (mis) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 2'b01;
          end else begin
            bus_req <= 1'b1;
            bus_we <= req_we && fw;
            state <= !req_we ? RD : fw ? WR : RMW_RD;
          end
        end
        RD, RMW_RD, RMW_WR, WR: begin
          if (ack) begin
            bus_req <= 1'b0;
            cnt <= '0;
            if (state == RMW_RD) begin
              state <= RMW_WR;
              bus_we <= 1'b1;
              bus_wd <= merged;
            end else begin
              state <= RESP;
              resp_valid <= 1'b1;
              bus_we <= 1'b0;
              resp_rdata <= state == RD ? ld : '0;
            end
          end else if (tmo) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 2'b10;
            bus_req <= 1'b0;
            bus_we <= 1'b0;
            cnt <= '0;
          end else if (bus_req) cnt <= cnt + 1'b1;
          else bus_req <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          req_ready <= 1'b1;
          busy <= 1'b0;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of a 32-bit (TIMEOUT=4) and a 64-bit instance of mem_access_unit.
module tb_mem_access_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;

  logic a_rv = 0, a_rr, a_we = 0, a_un = 0, a_vv, a_bz, a_br, a_bw, a_ak = 0;
  logic [1:0] a_sz = 0, a_er;
  logic [31:0] a_ad = 0, a_wd = 0, a_rd, a_ba, a_bwd, a_brd = 0;
  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_rv), .req_ready(a_rr), .req_we(a_we), .req_size(a_sz),
    .req_unsigned(a_un), .req_addr(a_ad), .req_wdata(a_wd), .resp_valid(a_vv), .resp_rdata(a_rd),
    .resp_err(a_er), .busy(a_bz), .bus_req(a_br), .bus_we(a_bw), .bus_addr(a_ba), .bus_wd(a_bwd),
    .bus_ack(a_ak), .bus_rd(a_brd));

  logic b_rv = 0, b_rr, b_we = 0, b_un = 0, b_vv, b_bz, b_br, b_bw, b_ak = 0;
  logic [1:0] b_sz = 0, b_er;
  logic [31:0] b_ad = 0, b_ba;
  logic [63:0] b_wd = 0, b_rd, b_bwd, b_brd = 0;
  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_rv), .req_ready(b_rr), .req_we(b_we), .req_size(b_sz),
    .req_unsigned(b_un), .req_addr(b_ad), .req_wdata(b_wd), .resp_valid(b_vv), .resp_rdata(b_rd),
    .resp_err(b_er), .busy(b_bz), .bus_req(b_br), .bus_we(b_bw), .bus_addr(b_ba), .bus_wd(b_bwd),
    .bus_ack(b_ak), .bus_rd(b_brd));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ld32(input string t, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] rd, input logic [31:0] ba, input logic [31:0] exp);
    chk({t, ".ready"}, a_rr, 1);
    a_rv = 1; a_we = 0; a_sz = s; a_un = u; a_ad = a;
    step();
    a_rv = 0;
    chk({t, ".bus_req"}, a_br, 1);
    chk({t, ".bus_we"}, a_bw, 0);
    chk({t, ".bus_addr"}, a_ba, ba);
    chk({t, ".busy"}, a_bz, 1);
    a_ak = 1; a_brd = rd;
    step();
    a_ak = 0;
    chk({t, ".resp_valid"}, a_vv, 1);
    chk({t, ".rdata"}, a_rd, exp);
    chk({t, ".err"}, a_er, 0);
    chk({t, ".bus_req_drop"}, a_br, 0);
    step();
    chk({t, ".resp_end"}, a_vv, 0);
    chk({t, ".ready_back"}, a_rr, 1);
  endtask

  task automatic st32(input string t, input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                      input logic [31:0] rd, input logic [31:0] ba, input logic [31:0] exp_wd);
    a_rv = 1; a_we = 1; a_sz = s; a_un = 0; a_ad = a; a_wd = w;
    step();
    a_rv = 0; a_we = 0;
    chk({t, ".rd_req"}, a_br, 1);
    chk({t, ".rd_we"}, a_bw, 0);
    chk({t, ".rd_addr"}, a_ba, ba);
    a_ak = 1; a_brd = rd;
    step();
    chk({t, ".gap"}, a_br, 0);
    step();
    chk({t, ".stray_ack_ignored"}, a_vv, 0);
    chk({t, ".wr_req"}, a_br, 1);
    chk({t, ".wr_we"}, a_bw, 1);
    chk({t, ".wr_addr"}, a_ba, ba);
    chk({t, ".wr_data"}, a_bwd, exp_wd);
    step();
    a_ak = 0;
    chk({t, ".resp_valid"}, a_vv, 1);
    chk({t, ".rdata"}, a_rd, 0);
    chk({t, ".err"}, a_er, 0);
    step();
  endtask

  task automatic ld64(input string t, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [63:0] rd, input logic [31:0] ba, input logic [63:0] exp);
    chk({t, ".ready"}, b_rr, 1);
    b_rv = 1; b_we = 0; b_sz = s; b_un = u; b_ad = a;
    step();
    b_rv = 0;
    chk({t, ".bus_req"}, b_br, 1);
    chk({t, ".bus_addr"}, b_ba, ba);
    b_ak = 1; b_brd = rd;
    step();
    b_ak = 0;
    chk({t, ".resp_valid"}, b_vv, 1);
    chk({t, ".rdata"}, b_rd, exp);
    chk({t, ".err"}, b_er, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(); step();
    chk("rst.ready", a_rr, 1);
    chk("rst.busy", a_bz, 0);
    chk("rst.bus_req", a_br, 0);
    chk("rst.resp_valid", a_vv, 0);
    chk("rst.rdata", a_rd, 0);
    chk("rst64.ready", b_rr, 1);
    rst_n = 1;
    step();

    ld32("lb_s", 32'h103, 2'd0, 0, 32'h8899AABB, 32'h100, 32'hFFFFFF88);
    ld32("lbu", 32'h103, 2'd0, 1, 32'h8899AABB, 32'h100, 32'h00000088);
    ld32("lb0", 32'h100, 2'd0, 0, 32'h8899AA3B, 32'h100, 32'h0000003B);
    ld32("lh_hi", 32'h102, 2'd1, 0, 32'h8899AABB, 32'h100, 32'hFFFF8899);
    ld32("lhu_lo", 32'h100, 2'd1, 1, 32'h8899AABB, 32'h100, 32'h0000AABB);
    ld32("lw", 32'h104, 2'd2, 0, 32'h8899AABB, 32'h104, 32'h8899AABB);

    st32("sh", 32'h202, 2'd1, 32'h00001234, 32'hDEADBEEF, 32'h200, 32'h1234BEEF);
    st32("sb", 32'h201, 2'd0, 32'hFFFFFFAB, 32'h11223344, 32'h200, 32'h1122AB44);

    a_rv = 1; a_we = 1; a_sz = 2'd2; a_ad = 32'h300; a_wd = 32'hCAFEF00D;
    step();
    a_rv = 0; a_we = 0;
    chk("sw.req", a_br, 1);
    chk("sw.we", a_bw, 1);
    chk("sw.addr", a_ba, 32'h300);
    chk("sw.wd", a_bwd, 32'hCAFEF00D);
    a_ak = 1;
    step();
    a_ak = 0;
    chk("sw.resp_valid", a_vv, 1);
    chk("sw.err", a_er, 0);
    step();

    // accept cycle counts as the first of the two cycles
    a_rv = 1; a_sz = 2'd2; a_ad = 32'h301;
    step();
    a_rv = 0;
    chk("mis_lw.resp_valid", a_vv, 1);
    chk("mis_lw.err", a_er, 2'b01);
    chk("mis_lw.bus_req", a_br, 0);
    chk("mis_lw.rdata", a_rd, 0);
    step();
    chk("mis_lw.ready", a_rr, 1);
    a_rv = 1; a_we = 1; a_sz = 2'd1; a_ad = 32'h201;
    step();
    a_rv = 0; a_we = 0;
    chk("mis_sh.err", a_er, 2'b01);
    chk("mis_sh.bus_req", a_br, 0);
    step();
    a_rv = 1; a_sz = 2'd3; a_ad = 32'h308;
    step();
    a_rv = 0;
    chk("ld_on32.err", a_er, 2'b01);
    step();

    a_rv = 1; a_sz = 2'd2; a_ad = 32'h400;
    step();
    a_rv = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo.wait%0d", i), {a_br, a_vv}, 2'b10);
      if (i < 3) step();
    end
    step();
    chk("tmo.resp_valid", a_vv, 1);
    chk("tmo.err", a_er, 2'b10);
    chk("tmo.bus_req", a_br, 0);
    step();
    ld32("after_tmo", 32'h404, 2'd2, 0, 32'h01020304, 32'h404, 32'h01020304);

    a_rv = 1; a_we = 1; a_sz = 2'd0; a_ad = 32'h500; a_wd = 32'h55;
    step();
    a_rv = 0; a_we = 0; a_ak = 1; a_brd = 32'hFFFFFFFF;
    step();
    a_ak = 0;
    step();
    chk("rst_mid.in_write", a_br, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst_mid.bus_req", a_br, 0);
    chk("rst_mid.ready", a_rr, 1);
    chk("rst_mid.busy", a_bz, 0);
    chk("rst_mid.resp_valid", a_vv, 0);
    a_ak = 1;
    step();
    a_ak = 0;
    chk("rst_mid.stray_resp", a_vv, 0);
    chk("rst_mid.stray_bus_req", a_br, 0);
    step();
    chk("rst_mid.stray_resp2", a_vv, 0);

    ld64("ld", 32'h08, 2'd3, 0, 64'h0123456789ABCDEF, 32'h08, 64'h0123456789ABCDEF);
    ld64("lw_hi", 32'h0C, 2'd2, 0, 64'h0123456789ABCDEF, 32'h08, 64'h0000000001234567);
    ld64("lw_lo", 32'h08, 2'd2, 0, 64'h0123456789ABCDEF, 32'h08, 64'hFFFFFFFF89ABCDEF);
    ld64("lwu_lo", 32'h08, 2'd2, 1, 64'h0123456789ABCDEF, 32'h08, 64'h0000000089ABCDEF);
    ld64("lh6", 32'h0E, 2'd1, 0, 64'h8123456789ABCDEF, 32'h08, 64'hFFFFFFFFFFFF8123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
